sample_fifo: RTL

//   Synchronous byte FIFO, first-word-fall-through (FWFT), directly upstream of the PSK modulator.

---
 rtl/sample_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through byte FIFO feeding the PSK modulator.
// Define SAMPLE_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sample_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AF_THRESHOLD = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LvlFull = LW'(DEPTH);
    localparam logic [LW-1:0] LvlAf   = LW'(AF_THRESHOLD);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, full_q, af_q;
    logic          push, pop;

    assign push = wr_en & ~full_q;
    assign pop  = rd & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Status flags are registered from the next level so they line up with level_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= (level_d == '0);
            full_q   <= (level_d == LvlFull);
            af_q     <= (level_d >= LvlAf);
        end
    end

    // Storage has no reset; only pointer state is cleared.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data     = mem[rd_ptr_q];
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign level       = level_q;

`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        ovf_d = (ovf_q & ~err_clr) | (wr_en & full_q);
        unf_d = (unf_q & ~err_clr) | (rd & empty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
